// File: rtl/skinny_sbox8_dom1_ctrl.sv
// -----------------------------------------------------------------------------
// skinny_sbox8_dom1_ctrl
//
// Sequencing controller for a first-order DOM-masked SKINNY-128 8-bit S-box.
// The controller accepts one masked byte, waits for one fresh 16-bit refresh
// mask from the PRNG, and then drives the S-box share inputs and the r input.
// It holds them stable for LATENCY cycles, captures the S-box output shares,
// and presents them on a valid/ready output port. Only one evaluation is in
// flight at a time. Evaluations never overlap, so a new byte is accepted only
// after the previous result has been taken.
//
// Parameters
//   LATENCY   cycles the attached S-box needs stable inputs (legal 1..15)
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_s0/in_s1 are the two shares
//   rnd_valid/rnd_ready   refresh-mask handshake; rnd is the 16-bit mask
//   sb_si0/sb_si1/sb_r    registered drive to the S-box share and r inputs
//   sb_bo0/sb_bo1         S-box output shares
//   out_valid/out_ready   result handshake; out_s0/out_s1 are the shares
//   busy                  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module skinny_sbox8_dom1_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_s0,
    input  logic [7:0]  in_s1,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    input  logic [15:0] rnd,
    output logic [7:0]  sb_si0,
    output logic [7:0]  sb_si1,
    output logic [15:0] sb_r,
    input  logic [7:0]  sb_bo0,
    input  logic [7:0]  sb_bo1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_s0,
    output logic [7:0]  out_s1,
    output logic        busy
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RND = 2'd1;
    localparam logic [1:0] ST_EVAL     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Last counter value of the evaluation window. The counter is cleared on
    // EVAL entry and only ever compared against this value, so it never wraps.
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       out_valid_reg;
    logic       out_valid_next;

    // Register-bank control strobes, decoded once and shared by every lane
    logic hold_load;
    logic hold_clr;
    logic sb_load;
    logic sb_clr;
    logic out_cap;
    logic out_clr;

    // Handshake events
    logic in_fire;
    logic rnd_fire;
    logic out_fire;

    // Assembled share vectors (each bit is owned by its own lane below)
    logic [7:0]  si0_reg;
    logic [7:0]  si1_reg;
    logic [7:0]  out0_reg;
    logic [7:0]  out1_reg;
    logic [15:0] r_reg;

    // -------------------------------------------------------------------------
    // Handshake outputs decode directly from the state register
    // -------------------------------------------------------------------------
    assign in_ready  = (state_reg == ST_IDLE);
    assign rnd_ready = (state_reg == ST_WAIT_RND);
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = out_valid_reg;

    assign in_fire  = in_valid  & in_ready;
    assign rnd_fire = rnd_valid & rnd_ready;
    assign out_fire = out_valid_reg & out_ready;

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        hold_load      = 1'b0;
        hold_clr       = 1'b0;
        sb_load        = 1'b0;
        sb_clr         = 1'b0;
        out_cap        = 1'b0;
        out_clr        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The byte goes into the hold registers only; the S-box
                // inputs stay at zero until the refresh mask is available.
                if (in_fire) begin
                    hold_load  = 1'b1;
                    state_next = ST_WAIT_RND;
                end
            end

            ST_WAIT_RND: begin
                // Shares and mask reach the S-box on the same edge, so the
                // S-box never sees unrefreshed shares.
                if (rnd_fire) begin
                    sb_load    = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = ST_EVAL;
                end
            end

            ST_EVAL: begin
                if (cnt_reg == LAT_LAST) begin
                    out_cap        = 1'b1;
                    out_valid_next = 1'b1;
                    sb_clr         = 1'b1;
                    hold_clr       = 1'b1;
                    cnt_next       = 4'd0;
                    state_next     = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_DONE: begin
                // Result stays put until the consumer takes it; no new input
                // is accepted here even if out_ready is already high.
                if (out_fire) begin
                    out_clr        = 1'b1;
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                cnt_next       = 4'd0;
                out_valid_next = 1'b0;
                hold_clr       = 1'b1;
                sb_clr         = 1'b1;
                out_clr        = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM, counter and output-valid registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Share-0 lanes: one hold / S-box-drive / result flop per bit. Each lane
    // only ever touches share-0 bits, so no logic cone mixes the two shares
    // of the same bit.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_share0_lane
            logic hold_bit_reg;
            logic si_bit_reg;
            logic out_bit_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_bit_reg <= 1'b0;
                    si_bit_reg   <= 1'b0;
                    out_bit_reg  <= 1'b0;
                end else begin
                    if (hold_load) begin
                        hold_bit_reg <= in_s0[gi];
                    end else if (hold_clr) begin
                        hold_bit_reg <= 1'b0;
                    end

                    if (sb_load) begin
                        si_bit_reg <= hold_bit_reg;
                    end else if (sb_clr) begin
                        si_bit_reg <= 1'b0;
                    end

                    if (out_cap) begin
                        out_bit_reg <= sb_bo0[gi];
                    end else if (out_clr) begin
                        out_bit_reg <= 1'b0;
                    end
                end
            end

            assign si0_reg[gi]  = si_bit_reg;
            assign out0_reg[gi] = out_bit_reg;
        end

        // ---------------------------------------------------------------------
        // Share-1 lanes: mirror of the share-0 lanes, kept physically separate.
        // ---------------------------------------------------------------------
        for (gi = 0; gi < 8; gi++) begin : g_share1_lane
            logic hold_bit_reg;
            logic si_bit_reg;
            logic out_bit_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_bit_reg <= 1'b0;
                    si_bit_reg   <= 1'b0;
                    out_bit_reg  <= 1'b0;
                end else begin
                    if (hold_load) begin
                        hold_bit_reg <= in_s1[gi];
                    end else if (hold_clr) begin
                        hold_bit_reg <= 1'b0;
                    end

                    if (sb_load) begin
                        si_bit_reg <= hold_bit_reg;
                    end else if (sb_clr) begin
                        si_bit_reg <= 1'b0;
                    end

                    if (out_cap) begin
                        out_bit_reg <= sb_bo1[gi];
                    end else if (out_clr) begin
                        out_bit_reg <= 1'b0;
                    end
                end
            end

            assign si1_reg[gi]  = si_bit_reg;
            assign out1_reg[gi] = out_bit_reg;
        end

        // ---------------------------------------------------------------------
        // Refresh-mask lanes: rnd is sampled only on the rnd handshake, so
        // each mask is used for exactly one evaluation.
        // ---------------------------------------------------------------------
        for (gi = 0; gi < 16; gi++) begin : g_rnd_lane
            logic r_bit_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bit_reg <= 1'b0;
                end else if (sb_load) begin
                    r_bit_reg <= rnd[gi];
                end else if (sb_clr) begin
                    r_bit_reg <= 1'b0;
                end
            end

            assign r_reg[gi] = r_bit_reg;
        end
    endgenerate

    assign sb_si0 = si0_reg;
    assign sb_si1 = si1_reg;
    assign sb_r   = r_reg;
    assign out_s0 = out0_reg;
    assign out_s1 = out1_reg;

endmodule
